// File: rtl/control_unit_phase_2.sv
// Decode-stage control unit with a sequencer for LDM, CALL/RET/RTI and
// interrupt entry. Ports: i_clk, i_reset, i_op_code, i_interrupt, i_stall
// in; ID/EX control bundle, o_stall (freeze fetch/PC) and o_busy out.
module control_unit_phase_2 #(
  parameter int PC_WORDS = 2,
  parameter int ALU_FN_W = 3,
  localparam int SEL_W = (PC_WORDS > 1) ? $clog2(PC_WORDS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [4:0]          i_op_code,
  input  logic                i_interrupt,
  input  logic                i_stall,
  output logic [ALU_FN_W-1:0] o_alu_function,
  output logic [1:0]          o_wb_selector,
  output logic                o_write_back,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_imm,
  output logic                o_stack_operation,
  output logic                o_stack_function,
  output logic                o_push_pc,
  output logic                o_pop_pc,
  output logic                o_push_flags,
  output logic                o_pop_flags,
  output logic [SEL_W-1:0]    o_pc_word_sel,
  output logic                o_branch_operation,
  output logic [1:0]          o_branch_selector,
  output logic                o_int_vector,
  output logic                o_change_carry,
  output logic                o_carry_value,
  output logic                o_output_port,
  output logic                o_read1,
  output logic                o_read2,
  output logic                o_stall,
  output logic                o_busy
);

  localparam logic [4:0] OP_NOT  = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_STD  = 5'h03;
  localparam logic [4:0] OP_LDM  = 5'h04;
  localparam logic [4:0] OP_LDD  = 5'h05;
  localparam logic [4:0] OP_PUSH = 5'h06;
  localparam logic [4:0] OP_POP  = 5'h07;
  localparam logic [4:0] OP_CALL = 5'h08;
  localparam logic [4:0] OP_RET  = 5'h09;
  localparam logic [4:0] OP_RTI  = 5'h0A;
  localparam logic [4:0] OP_JZ   = 5'h0B;
  localparam logic [4:0] OP_JMP  = 5'h0C;
  localparam logic [4:0] OP_SETC = 5'h0D;
  localparam logic [4:0] OP_CLRC = 5'h0E;
  localparam logic [4:0] OP_OUT  = 5'h0F;

  localparam logic [ALU_FN_W-1:0] ALU_NOT = ALU_FN_W'(1);
  localparam logic [ALU_FN_W-1:0] ALU_ADD = ALU_FN_W'(2);
  localparam logic [SEL_W-1:0]    LAST    = SEL_W'(PC_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, IMM, PUSH_PC, PUSH_FLAGS,
    VECTOR, CALL_JMP, POP_FLAGS, POP_PC
  } state_t;

  typedef struct packed {
    logic [ALU_FN_W-1:0] alu;
    logic [1:0]          wbs;
    logic                wb;
    logic                mrd;
    logic                mwr;
    logic                imm;
    logic                sop;
    logic                sfn;
    logic                ppc;
    logic                popc;
    logic                pfl;
    logic                popfl;
    logic [SEL_W-1:0]    sel;
    logic                bop;
    logic [1:0]          bsel;
    logic                ivec;
    logic                chc;
    logic                cval;
    logic                outp;
    logic                r1;
    logic                r2;
    logic                stall;
  } ctl_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;   // 1: interrupt entry, 0: CALL
  logic             pend_q, pend_d;
  logic             take;
  ctl_t             c, o;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
    end
  end

  // A request on the entry edge re-arms pending (level source).
  assign pend_d = i_interrupt | (pend_q & ~take);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    take    = 1'b0;
    c       = '0;
    if (i_stall) begin
      c.stall = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            c.stall = 1'b1;
            take    = 1'b1;
            cnt_d   = '0;
            src_d   = 1'b1;
            state_d = PUSH_PC;
          end else begin
            case (i_op_code)
              OP_NOT: begin
                c.alu = ALU_NOT; c.wb = 1'b1; c.r1 = 1'b1;
              end
              OP_ADD: begin
                c.alu = ALU_ADD; c.wb = 1'b1;
                c.r1 = 1'b1; c.r2 = 1'b1;
              end
              OP_STD: begin
                c.mwr = 1'b1; c.r1 = 1'b1; c.r2 = 1'b1;
              end
              OP_LDM: state_d = IMM;
              OP_LDD: begin
                c.mrd = 1'b1; c.wbs = 2'd1;
                c.wb = 1'b1; c.r1 = 1'b1;
              end
              OP_PUSH: begin
                c.sop = 1'b1; c.mwr = 1'b1; c.r1 = 1'b1;
              end
              OP_POP: begin
                c.sop = 1'b1; c.sfn = 1'b1; c.mrd = 1'b1;
                c.wbs = 2'd1; c.wb = 1'b1;
              end
              OP_CALL: begin
                c.stall = 1'b1; cnt_d = '0;
                src_d = 1'b0; state_d = PUSH_PC;
              end
              OP_RET: begin
                c.stall = 1'b1; cnt_d = LAST; state_d = POP_PC;
              end
              OP_RTI: begin
                c.stall = 1'b1; state_d = POP_FLAGS;
              end
              OP_JZ: begin
                c.bop = 1'b1; c.bsel = 2'd1; c.r1 = 1'b1;
              end
              OP_JMP: begin
                c.bop = 1'b1; c.r1 = 1'b1;
              end
              OP_SETC: begin
                c.chc = 1'b1; c.cval = 1'b1;
              end
              OP_CLRC: c.chc = 1'b1;
              OP_OUT: begin
                c.outp = 1'b1; c.r1 = 1'b1;
              end
              default: ;
            endcase
          end
        end
        IMM: begin
          c.imm = 1'b1; c.wb = 1'b1; c.wbs = 2'd2;
          state_d = IDLE;
        end
        PUSH_PC: begin
          c.ppc = 1'b1; c.mwr = 1'b1; c.sop = 1'b1;
          c.sel = cnt_q; c.stall = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = src_q ? PUSH_FLAGS : CALL_JMP;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
        PUSH_FLAGS: begin
          c.pfl = 1'b1; c.mwr = 1'b1; c.sop = 1'b1;
          c.stall = 1'b1;
          state_d = VECTOR;
        end
        VECTOR: begin
          c.ivec = 1'b1;
          state_d = IDLE;
        end
        CALL_JMP: begin
          c.bop = 1'b1; c.r1 = 1'b1;
          state_d = IDLE;
        end
        POP_FLAGS: begin
          c.popfl = 1'b1; c.mrd = 1'b1;
          c.sop = 1'b1; c.sfn = 1'b1; c.stall = 1'b1;
          cnt_d = LAST; state_d = POP_PC;
        end
        POP_PC: begin
          c.popc = 1'b1; c.mrd = 1'b1;
          c.sop = 1'b1; c.sfn = 1'b1; c.sel = cnt_q;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            c.stall = 1'b1;
            cnt_d = cnt_q - SEL_W'(1);
          end
        end
      endcase
    end
  end

  // Bundle is a bubble while reset is held, whatever sits in decode.
  always_comb begin
    o = c;
    if (i_reset) o = '0;
  end

  assign o_alu_function     = o.alu;
  assign o_wb_selector      = o.wbs;
  assign o_write_back       = o.wb;
  assign o_mem_read         = o.mrd;
  assign o_mem_write        = o.mwr;
  assign o_imm              = o.imm;
  assign o_stack_operation  = o.sop;
  assign o_stack_function   = o.sfn;
  assign o_push_pc          = o.ppc;
  assign o_pop_pc           = o.popc;
  assign o_push_flags       = o.pfl;
  assign o_pop_flags        = o.popfl;
  assign o_pc_word_sel      = o.sel;
  assign o_branch_operation = o.bop;
  assign o_branch_selector  = o.bsel;
  assign o_int_vector       = o.ivec;
  assign o_change_carry     = o.chc;
  assign o_carry_value      = o.cval;
  assign o_output_port      = o.outp;
  assign o_read1            = o.r1;
  assign o_read2            = o.r2;
  assign o_stall            = o.stall;
  assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_control_unit_phase_2.sv
// Bench for control_unit_phase_2: directed vector table, reset corner
// cases, then random stimulus against a queue-based reference model.
module tb_control_unit_phase_2;

  localparam int PCW = 2;

  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] wbs;
    logic       wb;
    logic       mrd;
    logic       mwr;
    logic       imm;
    logic       sop;
    logic       sfn;
    logic       ppc;
    logic       popc;
    logic       pfl;
    logic       popfl;
    logic       sel;
    logic       bop;
    logic [1:0] bsel;
    logic       ivec;
    logic       chc;
    logic       cval;
    logic       outp;
    logic       r1;
    logic       r2;
    logic       stall;
  } exp_t;

  typedef struct {
    logic [4:0] op;
    logic       intr;
    logic       st;
    exp_t       e;
    logic       busy;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [4:0] i_op_code = 5'h02;
  logic       i_interrupt = 1'b0;
  logic       i_stall = 1'b0;
  logic [2:0] o_alu_function;
  logic [1:0] o_wb_selector, o_branch_selector;
  logic o_write_back, o_mem_read, o_mem_write, o_imm;
  logic o_stack_operation, o_stack_function;
  logic o_push_pc, o_pop_pc, o_push_flags, o_pop_flags;
  logic [0:0] o_pc_word_sel;
  logic o_branch_operation, o_int_vector;
  logic o_change_carry, o_carry_value, o_output_port;
  logic o_read1, o_read2, o_stall, o_busy;

  control_unit_phase_2 #(.PC_WORDS(PCW), .ALU_FN_W(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op_code(i_op_code),
    .i_interrupt(i_interrupt), .i_stall(i_stall),
    .o_alu_function(o_alu_function), .o_wb_selector(o_wb_selector),
    .o_write_back(o_write_back), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_imm(o_imm),
    .o_stack_operation(o_stack_operation),
    .o_stack_function(o_stack_function),
    .o_push_pc(o_push_pc), .o_pop_pc(o_pop_pc),
    .o_push_flags(o_push_flags), .o_pop_flags(o_pop_flags),
    .o_pc_word_sel(o_pc_word_sel),
    .o_branch_operation(o_branch_operation),
    .o_branch_selector(o_branch_selector),
    .o_int_vector(o_int_vector), .o_change_carry(o_change_carry),
    .o_carry_value(o_carry_value), .o_output_port(o_output_port),
    .o_read1(o_read1), .o_read2(o_read2),
    .o_stall(o_stall), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  exp_t act;
  assign act = {o_alu_function, o_wb_selector, o_write_back,
                o_mem_read, o_mem_write, o_imm,
                o_stack_operation, o_stack_function,
                o_push_pc, o_pop_pc, o_push_flags, o_pop_flags,
                o_pc_word_sel, o_branch_operation, o_branch_selector,
                o_int_vector, o_change_carry, o_carry_value,
                o_output_port, o_read1, o_read2, o_stall};

  int total = 0;
  int bad = 0;

  function automatic exp_t bub(input logic st);
    exp_t e = '0; e.stall = st; return e;
  endfunction
  function automatic exp_t kpush(input int w);
    exp_t e = '0;
    e.ppc = 1; e.mwr = 1; e.sop = 1; e.sel = 1'(w); e.stall = 1;
    return e;
  endfunction
  function automatic exp_t kpfl();
    exp_t e = '0;
    e.pfl = 1; e.mwr = 1; e.sop = 1; e.stall = 1;
    return e;
  endfunction
  function automatic exp_t kvec();
    exp_t e = '0; e.ivec = 1; return e;
  endfunction
  function automatic exp_t kcj();
    exp_t e = '0; e.bop = 1; e.r1 = 1; return e;
  endfunction
  function automatic exp_t kpopfl();
    exp_t e = '0;
    e.popfl = 1; e.mrd = 1; e.sop = 1; e.sfn = 1; e.stall = 1;
    return e;
  endfunction
  function automatic exp_t kpop(input int w);
    exp_t e = '0;
    e.popc = 1; e.mrd = 1; e.sop = 1; e.sfn = 1;
    e.sel = 1'(w); e.stall = (w != 0);
    return e;
  endfunction
  function automatic exp_t kimm();
    exp_t e = '0; e.imm = 1; e.wb = 1; e.wbs = 2; return e;
  endfunction

  // Single-cycle instruction bundles.
  function automatic exp_t dec(input logic [4:0] op);
    exp_t e = '0;
    case (op)
      5'h01: begin e.alu = 1; e.wb = 1; e.r1 = 1; end
      5'h02: begin e.alu = 2; e.wb = 1; e.r1 = 1; e.r2 = 1; end
      5'h03: begin e.mwr = 1; e.r1 = 1; e.r2 = 1; end
      5'h05: begin e.mrd = 1; e.wbs = 1; e.wb = 1; e.r1 = 1; end
      5'h06: begin e.sop = 1; e.mwr = 1; e.r1 = 1; end
      5'h07: begin
        e.sop = 1; e.sfn = 1; e.mrd = 1; e.wbs = 1; e.wb = 1;
      end
      5'h0B: begin e.bop = 1; e.bsel = 1; e.r1 = 1; end
      5'h0C: begin e.bop = 1; e.r1 = 1; end
      5'h0D: begin e.chc = 1; e.cval = 1; end
      5'h0E: e.chc = 1;
      5'h0F: begin e.outp = 1; e.r1 = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Reference: multi-cycle ops expand into a queue of future bundles.
  exp_t mq[$];
  bit   mpend;

  task automatic mreset();
    mq.delete(); mpend = 0;
  endtask

  task automatic mstep(input logic [4:0] op, input bit intr,
                       input bit st, output exp_t e, output bit busy);
    busy = (mq.size() != 0);
    e = '0;
    if (st) begin
      e.stall = 1;
    end else if (mq.size() != 0) begin
      e = mq.pop_front();
    end else if (mpend) begin
      e.stall = 1; mpend = 0;
      for (int w = 0; w < PCW; w++) mq.push_back(kpush(w));
      mq.push_back(kpfl());
      mq.push_back(kvec());
    end else begin
      case (op)
        5'h04: mq.push_back(kimm());
        5'h08: begin
          e.stall = 1;
          for (int w = 0; w < PCW; w++) mq.push_back(kpush(w));
          mq.push_back(kcj());
        end
        5'h09: begin
          e.stall = 1;
          for (int w = PCW - 1; w >= 0; w--) mq.push_back(kpop(w));
        end
        5'h0A: begin
          e.stall = 1;
          mq.push_back(kpopfl());
          for (int w = PCW - 1; w >= 0; w--) mq.push_back(kpop(w));
        end
        default: e = dec(op);
      endcase
    end
    if (intr) mpend = 1;
  endtask

  task automatic chk(input string nm, input exp_t e, input logic eb);
    total++;
    if (act !== e || o_busy !== eb) begin
      bad++;
      $display("FAIL %s: got bundle=%h busy=%b, want bundle=%h busy=%b",
               nm, act, o_busy, e, eb);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic intr,
                       input logic st);
    @(negedge i_clk);
    i_op_code = op; i_interrupt = intr; i_stall = st;
    #1;
  endtask

  task automatic mstep_chk(input string nm, input logic [4:0] op,
                           input logic intr, input logic st);
    exp_t e; bit b;
    drive(op, intr, st);
    mstep(op, intr, st, e, b);
    chk(nm, e, b);
  endtask

  // Reset pulse inside one low clock phase; no edge sees it.
  task automatic rst_pulse(input string nm);
    exp_t e; bit b;
    @(negedge i_clk);
    i_op_code = 5'h02; i_interrupt = 0; i_stall = 0; i_reset = 1;
    #1;
    chk(nm, '0, 1'b0);
    mreset();
    #2 i_reset = 0;
    mstep(5'h02, 0, 0, e, b);
  endtask

  vec_t tbl[$];

  task automatic add(input logic [4:0] op, input logic intr,
                     input logic st, input exp_t e, input logic busy);
    vec_t v;
    v.op = op; v.intr = intr; v.st = st; v.e = e; v.busy = busy;
    tbl.push_back(v);
  endtask

  initial begin
    exp_t e; bit b;
    logic [4:0] op;
    add(5'h01, 0, 0, dec(5'h01), 0);
    add(5'h04, 0, 0, bub(0), 0);
    add(5'h12, 0, 0, kimm(), 1);
    add(5'h02, 1, 0, dec(5'h02), 0);
    add(5'h0F, 0, 0, bub(1), 0);
    add(5'h0F, 0, 0, kpush(0), 1);
    add(5'h0F, 0, 0, kpush(1), 1);
    add(5'h0F, 0, 0, kpfl(), 1);
    add(5'h0F, 0, 0, kvec(), 1);
    add(5'h0F, 0, 0, dec(5'h0F), 0);
    add(5'h0A, 0, 0, bub(1), 0);
    add(5'h0A, 0, 0, kpopfl(), 1);
    add(5'h0A, 0, 0, kpop(1), 1);
    add(5'h0A, 0, 0, kpop(0), 1);
    add(5'h00, 0, 0, bub(0), 0);
    add(5'h08, 0, 0, bub(1), 0);
    add(5'h08, 0, 0, kpush(0), 1);
    add(5'h08, 0, 1, bub(1), 1);
    add(5'h08, 0, 1, bub(1), 1);
    add(5'h08, 0, 0, kpush(1), 1);
    add(5'h08, 0, 0, kcj(), 1);
    add(5'h0B, 0, 0, dec(5'h0B), 0);
    add(5'h09, 0, 0, bub(1), 0);
    add(5'h09, 0, 0, kpop(1), 1);
    add(5'h09, 0, 0, kpop(0), 1);
    add(5'h0D, 0, 0, dec(5'h0D), 0);
    add(5'h1F, 0, 0, bub(0), 0);
    add(5'h08, 0, 0, bub(1), 0);
    add(5'h08, 1, 0, kpush(0), 1);
    add(5'h08, 0, 0, kpush(1), 1);
    add(5'h08, 0, 0, kcj(), 1);
    add(5'h0E, 0, 0, bub(1), 0);
    add(5'h0E, 0, 0, kpush(0), 1);
    add(5'h0E, 0, 0, kpush(1), 1);
    add(5'h0E, 0, 0, kpfl(), 1);
    add(5'h0E, 0, 0, kvec(), 1);
    add(5'h0E, 0, 0, dec(5'h0E), 0);
    add(5'h03, 0, 1, bub(1), 0);
    add(5'h03, 0, 0, dec(5'h03), 0);

    // Reset held with ADD in decode: bubble, then ADD after release.
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_bubble", '0, 1'b0);
    i_reset = 0;
    mreset();
    mstep_chk("post_reset_add", 5'h02, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].intr, tbl[i].st);
      mstep(tbl[i].op, tbl[i].intr, tbl[i].st, e, b);
      chk($sformatf("tbl%0d", i), tbl[i].e, tbl[i].busy);
    end

    // Reset in POP_PC with an interrupt pending: both discarded.
    mstep_chk("ret_start", 5'h09, 0, 0);
    mstep_chk("ret_pop1", 5'h09, 1, 0);
    rst_pulse("rst_mid_pop");
    drive(5'h00, 0, 0);
    chk("rst_clears_pend", bub(0), 1'b0);
    mstep(5'h00, 0, 0, e, b);
    mstep_chk("ret2_start", 5'h09, 0, 0);
    mstep_chk("ret2_pop1", 5'h09, 0, 0);
    mstep_chk("ret2_pop0", 5'h09, 0, 0);
    mstep_chk("ret2_idle", 5'h00, 0, 0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_pulse($sformatf("rnd_rst%0d", n));
      end else begin
        if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
        else op = 5'($urandom_range(0, 15));
        mstep_chk($sformatf("rnd%0d", n), op,
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 5) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
